// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RISC-V M-extension multiply/divide engine. It produces one
// result bit per clock. A shift-add multiplier and a restoring divider share
// one pair of WIDTH-bit accumulators. Signs are stripped when an operation is
// accepted and reapplied in a single FIX cycle.
//
// Ports:
//   clock   - rising-edge clock
//   reset_  - asynchronous active-low reset
//   start   - operation request, sampled only while ready
//   op      - funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b    - rs1 / rs2 operands
//   kill    - abort an in-flight operation (no done, result unchanged)
//   ready   - unit can accept start this cycle (IDLE or DONE)
//   busy    - operation in flight (CALC or FIX)
//   done    - one-cycle pulse, result valid
//   result  - registered result, held until the next completion
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  state_t             state;
  state_t             state_next;
  logic [2:0]         op_q;
  logic               res_neg;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               a_signed;
  logic               b_signed;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic               sign_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   fix_value;

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign accept = ready && start && !kill;

  // Operand conditioning at accept time. Work is done on magnitudes. The
  // sign of the final result is decided here, so FIX only has to negate.
  // With a zero divisor the quotient must be all ones whatever the operand
  // signs are, so its sign is forced positive. The remainder always follows
  // the dividend, which also makes rem-by-zero come back as a.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OP_MULH:        begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:      a_signed = 1'b1;
      OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        ;
    endcase
    a_neg  = a_signed && a[WIDTH-1];
    b_neg  = b_signed && b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
    case (op)
      OP_DIV, OP_DIVU: sign_in = (a_neg ^ b_neg) && !b_zero;
      OP_REM, OP_REMU: sign_in = a_neg;
      default:         sign_in = a_neg ^ b_neg;
    endcase
  end

  // One iteration of each algorithm.
  // Multiply: acc_hi holds the partial product and acc_lo holds the
  // multiplier. Shifting them right together builds the 2*WIDTH product.
  // Divide: acc_hi holds the partial remainder. acc_lo shifts dividend bits
  // out at the top while quotient bits enter at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  // Sign fix-up and output selection, used only in the FIX cycle.
  always_comb begin
    product     = {acc_hi, acc_lo};
    product_fix = res_neg ? -product : product;
    case (op_q)
      OP_MUL:                        fix_value = product_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_value = product_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fix_value = res_neg ? -acc_lo : acc_lo;
      OP_REM, OP_REMU:               fix_value = res_neg ? -acc_hi : acc_hi;
      default:                       fix_value = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. kill wins over everything, including a coincident start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (kill)                     state_next = IDLE;
        else if (cnt == CNT_W'(1))    state_next = FIX;
      end
      FIX:  state_next = kill ? IDLE : DONE;
      DONE: state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Corner cases such as a zero divisor or signed overflow fall
  // out of the restoring algorithm plus the sign rules above, so every
  // operation takes the same fixed latency.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      op_q    <= OP_MUL;
      res_neg <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      if (accept) begin
        op_q    <= op;
        res_neg <= sign_in;
        acc_hi  <= '0;
        acc_lo  <= op[2] ? a_mag : b_mag;
        opnd    <= op[2] ? b_mag : a_mag;
        cnt     <= CNT_W'(WIDTH);
      end else if (state == CALC) begin
        cnt <= cnt - CNT_W'(1);
        if (op_q[2]) begin
          if (!div_diff[WIDTH]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
        end
      end

      if (state == FIX && !kill) begin
        result <= fix_value;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. It uses a 32-bit instance and an
// 8-bit instance that share one clock and reset. The directed cases carry
// their expected values as constants. The random cases are compared with an
// arithmetic reference model built on 64-bit integers.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clock;
  logic        reset_;

  logic        start32, kill32, ready32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, result32;

  logic        start8, kill8, ready8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  int          checks;
  int          errors;
  logic [31:0] lastExp32;
  logic [31:0] lastExp8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_(reset_), .start(start32), .op(op32), .a(a32), .b(b32),
    .kill(kill32), .ready(ready32), .busy(busy32), .done(done32), .result(result32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_(reset_), .start(start8), .op(op8), .a(a8), .b(b8),
    .kill(kill8), .ready(ready8), .busy(busy8), .done(done8), .result(result8)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Stops a hung run with a failure line instead of letting it spin.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: RISC-V M-extension semantics at width w using plain
  // integer arithmetic. SystemVerilog signed / and % truncate toward zero,
  // which matches RISC-V.
  function automatic logic [31:0] refModel(input int w, input logic [2:0] o,
                                            input logic [31:0] x, input logic [31:0] y);
    longint mask, ux, uy, sx, sy, r;
    logic [63:0] rbits;
    mask = (longint'(1) <<< w) - 1;
    ux   = {32'b0, x} & mask;
    uy   = {32'b0, y} & mask;
    sx   = x[w-1] ? ux - (longint'(1) <<< w) : ux;
    sy   = y[w-1] ? uy - (longint'(1) <<< w) : uy;
    case (o)
      OP_MUL:    r = ux * uy;
      OP_MULH:   r = (sx * sy) >>> w;
      OP_MULHSU: r = (sx * uy) >>> w;
      OP_MULHU:  r = (ux * uy) >>> w;
      OP_DIV: begin
        if (uy == 0) r = mask;
        else if (sx == -(longint'(1) <<< (w - 1)) && sy == -1) r = ux;
        else r = sx / sy;
      end
      OP_DIVU:   r = (uy == 0) ? mask : ux / uy;
      OP_REM: begin
        if (uy == 0) r = ux;
        else if (sx == -(longint'(1) <<< (w - 1)) && sy == -1) r = 0;
        else r = sx % sy;
      end
      default:   r = (uy == 0) ? ux : ux % uy;
    endcase
    rbits = r & mask;
    return rbits[31:0];
  endfunction

  function automatic logic doneOf(input int w);
    return (w == 8) ? done8 : done32;
  endfunction

  function automatic logic [31:0] resultOf(input int w);
    return (w == 8) ? {24'b0, result8} : result32;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called just after a rising edge. Holds start for exactly one edge (E0)
  // and returns 1 time unit after that edge.
  task automatic applyStimulus(input int w, input logic [2:0] o,
                               input logic [31:0] x, input logic [31:0] y);
    if (w == 8) begin
      start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    end
    @(posedge clock);
    #1;
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  // Counts edges until done is seen. Returns -1 when the bound expires,
  // so the latency comparison that follows fails.
  task automatic waitDone(input int w, output int edges);
    edges = -1;
    for (int n = 1; n <= 2 * w + 20; n++) begin
      @(posedge clock);
      #1;
      if (doneOf(w)) begin
        edges = n;
        break;
      end
    end
  endtask

  // One full operation with latency, result and done-width checks.
  task automatic runCheck(input int w, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expected,
                          input string tag);
    int n;
    applyStimulus(w, o, x, y);
    waitDone(w, n);
    checkOutput({tag, " latency"}, n, w + 1);
    checkOutput({tag, " result"}, resultOf(w), expected);
    if (w == 8) lastExp8 = expected; else lastExp32 = expected;
    @(posedge clock);
    #1;
    checkOutput({tag, " done width"}, {31'b0, doneOf(w)}, 32'd0);
  endtask

  // Watches a number of edges and reports whether done ever rose.
  task automatic watchNoDone(input int w, input int cycles, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clock);
      #1;
      if (doneOf(w)) seen = 1'b1;
    end
  endtask

  initial begin
    int          n;
    logic        seen;
    logic [2:0]  o;
    logic [31:0] x, y, e;

    checks    = 0;
    errors    = 0;
    lastExp32 = 32'd0;
    lastExp8  = 32'd0;
    reset_    = 1'b0;
    start32 = 1'b0; kill32 = 1'b0; op32 = 3'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; kill8  = 1'b0; op8  = 3'b0; a8  = '0; b8  = '0;

    // Reset state
    #3;
    checkOutput("reset ready32",  {31'b0, ready32}, 32'd1);
    checkOutput("reset busy32",   {31'b0, busy32},  32'd0);
    checkOutput("reset done32",   {31'b0, done32},  32'd0);
    checkOutput("reset result32", result32,         32'd0);
    checkOutput("reset result8",  {24'b0, result8}, 32'd0);
    #9;
    reset_ = 1'b1;
    @(posedge clock);
    #1;

    // Multiply
    runCheck(32, OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "MUL 7*-3");
    runCheck(32, OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "MULH -1*-1");
    runCheck(32, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU max*max");
    runCheck(32, OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "MULHSU -1*2");

    // Divide
    runCheck(32, OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "DIV -7/2");
    runCheck(32, OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "REM -7/2");
    runCheck(32, OP_DIVU, 32'd100,      32'd7, 32'd14,       "DIVU 100/7");
    repeat (5) @(posedge clock);
    #1;
    checkOutput("result held", result32, 32'd14);
    runCheck(32, OP_REMU, 32'd100,      32'd7, 32'd2,        "REMU 100/7");

    // Corner cases
    runCheck(32, OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, "DIV 5/0");
    runCheck(32, OP_REMU, 32'd5,        32'd0,        32'd5,        "REMU 5/0");
    runCheck(32, OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV overflow");
    runCheck(32, OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        "REM overflow");

    // A start pulsed during CALC is ignored
    applyStimulus(32, OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clock);
    #1;
    start32 = 1'b1; op32 = OP_MUL; a32 = 32'd3; b32 = 32'd3;
    @(posedge clock);
    #1;
    start32 = 1'b0;
    waitDone(32, n);
    checkOutput("start in CALC latency", n + 5, 32'd33);
    checkOutput("start in CALC result", result32, 32'd14);
    lastExp32 = 32'd14;
    @(posedge clock);
    #1;
    checkOutput("start in CALC back to idle", {31'b0, ready32}, 32'd1);

    // kill sampled at edge E10
    applyStimulus(32, OP_MUL, 32'd1000, 32'd1000);
    repeat (9) @(posedge clock);
    #1;
    kill32 = 1'b1;
    @(posedge clock);
    #1;
    kill32 = 1'b0;
    checkOutput("kill busy",  {31'b0, busy32},  32'd0);
    checkOutput("kill ready", {31'b0, ready32}, 32'd1);
    watchNoDone(32, 40, seen);
    checkOutput("kill no done", {31'b0, seen}, 32'd0);
    checkOutput("kill result kept", result32, lastExp32);

    // start together with kill in IDLE
    start32 = 1'b1; kill32 = 1'b1; op32 = OP_MUL; a32 = 32'd9; b32 = 32'd9;
    @(posedge clock);
    #1;
    start32 = 1'b0; kill32 = 1'b0;
    checkOutput("start+kill busy", {31'b0, busy32}, 32'd0);
    watchNoDone(32, 40, seen);
    checkOutput("start+kill no done", {31'b0, seen}, 32'd0);
    checkOutput("start+kill result", result32, lastExp32);

    // Asynchronous reset between edges, just after E15
    applyStimulus(32, OP_MUL, 32'd123, 32'd456);
    repeat (15) @(posedge clock);
    #2;
    reset_ = 1'b0;
    #1;
    checkOutput("async reset ready",  {31'b0, ready32}, 32'd1);
    checkOutput("async reset busy",   {31'b0, busy32},  32'd0);
    checkOutput("async reset done",   {31'b0, done32},  32'd0);
    checkOutput("async reset result", result32,         32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock);
    #1;
    lastExp32 = 32'd0;
    lastExp8  = 32'd0;
    runCheck(32, OP_MUL, 32'd3, 32'd4, 32'd12, "MUL 3*4 after reset");

    // WIDTH=8 instance, back-to-back start in the DONE cycle
    applyStimulus(8, OP_MULHU, 32'hFF, 32'hFF);
    waitDone(8, n);
    checkOutput("w8 MULHU latency", n, 32'd9);
    checkOutput("w8 MULHU result", {24'b0, result8}, 32'hFE);
    applyStimulus(8, OP_DIVU, 32'hFF, 32'h10);
    checkOutput("w8 back-to-back accepted", {31'b0, busy8}, 32'd1);
    waitDone(8, n);
    checkOutput("w8 DIVU latency", n, 32'd9);
    checkOutput("w8 DIVU result", {24'b0, result8}, 32'h0F);
    lastExp8 = 32'h0F;
    @(posedge clock);
    #1;

    // Random operations against the reference model, WIDTH=32
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = $urandom_range(1, 15);
        default: ;
      endcase
      e = refModel(32, o, x, y);
      runCheck(32, o, x, y, e, $sformatf("rand32 #%0d op%0d", i, o));
    end

    // Random operations against the reference model, WIDTH=8
    for (int i = 0; i < 20; i++) begin
      o = 3'($urandom_range(0, 7));
      x = {24'b0, 8'($urandom)};
      y = {24'b0, 8'($urandom)};
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80; y = 32'hFF; end
        default: ;
      endcase
      e = refModel(8, o, x, y);
      runCheck(8, o, x, y, e, $sformatf("rand8 #%0d op%0d", i, o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised integer multiply/divide unit implementing the full RISC-V M-extension operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at operand width WIDTH. It sits beside the datapath ALU. The ALU's single-cycle `a*b` / `a/b` paths are replaced by this multi-cycle engine: a start/done handshake, one result bit per clock, abort support and RISC-V-exact corner-case results. The control FSM stalls the PC while `busy` is high.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when `ready`=1.
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 operand (multiplicand / dividend).
- b  input  WIDTH  rs2 operand (multiplier / divisor).
- kill  input  1  abort in-flight operation.
- ready  output  1  unit can accept `start` this cycle.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: `result` valid.
- result  output  WIDTH  registered result; held until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE. `ready` = (IDLE or DONE). `busy` = (CALC or FIX). `done` = DONE. All are decoded from registered state.
- Accept in IDLE or DONE on `start`=1 and `kill`=0:
  - latch `op`;
  - latch operand magnitudes, taking the two's-complement absolute value for signed operands (MULH: a and b signed; MULHSU: a signed; DIV/REM: both signed);
  - record result sign;
  - load counter = WIDTH; go to CALC.
- CALC, multiply: 2·WIDTH-bit shift-add accumulator, one multiplier bit per edge.
- CALC, divide: restoring division, one quotient bit per edge, WIDTH-bit remainder.
- CALC: counter decrements each edge; at counter = 1 go to FIX.
- FIX: apply sign and select the output, then register `result` and go to DONE.
  - MUL: low WIDTH bits. MULH/MULHSU/MULHU: high WIDTH bits of the signed-corrected 2·WIDTH product.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
- Divisor zero (DIV/DIVU): result = all ones. (REM/REMU): result = a.
- Signed overflow (DIV, a = 100…0, b = all ones): result = a. REM in the same case: result = 0.
- Corner-case results use the same fixed latency; no early termination.
- DONE lasts one cycle. Without `start` it goes to IDLE; with `start` it accepts new operands (back-to-back).
- `kill`=1 in CALC or FIX: next edge goes to IDLE. No `done`; `result` unchanged.
- `kill` in IDLE/DONE: go to/stay in IDLE; any coincident `start` is ignored.
- `start` while `busy`: ignored, no queuing.

## Timing
- Reset (asynchronous, immediate on `reset_` low):
  - state IDLE, counter 0, accumulators 0;
  - `result` = 0, `done` = 0, `busy` = 0, `ready` = 1.
- Reset mid-operation discards the operation; no `done`.
- Latency: `start` accepted at edge E0. CALC covers edges E1…E_WIDTH; FIX takes E_WIDTH+1.
- `done`=1 and the new `result` are visible in the cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32). `done` drops after the following edge.
- Throughput: one operation per WIDTH+2 cycles with back-to-back `start` in DONE.
- Operands `a`/`b`/`op` need be stable only in the accepting cycle.
- No combinational path from inputs to outputs.

## Test plan
- Multiply, WIDTH=32:
  - MUL 7×0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHU same operands → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
  - Each `done` is exactly 33 edges after accept and one cycle wide.
- Divide:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
  - `result` is held after `done` until the next completion.
- Corners:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All at 33-edge latency.
- Handshake:
  - `start` pulsed during CALC is ignored.
  - `kill` at edge E10 → IDLE next cycle, no `done`, `result` keeps its previous value.
  - `start` with `kill` in IDLE → stays IDLE.
- Reset: drive `reset_` low between clock edges at E15 → outputs clear immediately to `ready`=1, `busy`=0, `result`=0. After release, a new MUL 3×4 → 12.
- Parametrisation/back-to-back: WIDTH=8 instance, MULHU 0xFF×0xFF → 0xFE with `done` 9 edges after accept. A second `start` (DIVU 0xFF/0x10 → 0x0F) in the DONE cycle is accepted with no idle gap.
